cpu_irq_ctrl: RTL and testbench
===============================

Name: cpu_irq_ctrl

Overview:
- Prioritised interrupt controller between the CPU subsystem's interrupt sources (UART, ALU, mouse) and the PicoBlaze single interrupt input.
- Latches requests into pending bits, applies a software mask, and presents one interrupt at a time.
- On interrupt_ack, records which source is being serviced. Blocks further interrupts until firmware writes end-of-interrupt (EOI).
- Programmed from the PicoBlaze I/O port bus; replaces the plain OR of the three sources in the CPU top level.

Parameters:
- PORT_BASE, 8'hE0, base port_id of the 4-register window; PORT_BASE[1:0] must be 0.
- EDGE_MODE, 3'b111, per source: 1 = rising-edge latched, 0 = level. Bit 0 uart, bit 1 alu, bit 2 mouse.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- irq_src, input, 3, raw requests {mouse, alu, uart}; synchronous to clk.
- port_id, input, 8, PicoBlaze port address.
- write_strobe, input, 1, PicoBlaze write strobe.
- out_port, input, 8, PicoBlaze write data.
- interrupt, output, 1, registered interrupt request to PicoBlaze.
- interrupt_ack, input, 1, PicoBlaze interrupt acknowledge (one-cycle pulse).
- rd_data, output, 8, read data for the addressed register; 0 when not selected.
- rd_sel, output, 1, combinational; high when port_id[7:2] == PORT_BASE[7:2]. Top level uses it to mux rd_data onto in_port.
- irq_busy, output, 1, high in SERVICE state (debug/LED).

Behaviour:
- Register map, offset = port_id[1:0]:
  - +0 PEND: [2:0] pending bits. Read gives pending. Write is write-1-to-clear.
  - +1 MASK: [2:0] enables, R/W. Reset value 0.
  - +2 VEC: read-only. [7] valid, [1:0] source id (0 uart, 1 alu, 2 mouse, 3 none).
  - +3 EOI: write-only; any written value ends service. Reads as 0.
  - Unused bits read 0. Reads have no side effects.
  - A write takes effect when write_strobe is high and rd_sel is high, on that clock edge.
- Pending-bit set condition: edge mode sets on irq_src & ~irq_src_d (1-cycle registered copy). Level mode sets every cycle irq_src is high.
- If set and W1C hit the same bit in the same cycle, set wins.
- Pending bits latch regardless of mask. Masking only gates the request.
- req = |(PEND & MASK).
- State machine, 3 states:
  - IDLE: interrupt=0. Moves to REQ on the next edge when req=1.
  - REQ: interrupt=1, held until acknowledged.
    - interrupt_ack=1: go to SERVICE (takes priority over the withdrawal check).
    - Else if req=0 (pending cleared or masked): return to IDLE and drop interrupt.
  - SERVICE: interrupt=0 regardless of req; irq_busy=1. Returns to IDLE on an EOI write.
  - After EOI, if req=1, REQ is entered one cycle after IDLE.
- Ack capture, on the interrupt_ack cycle while in REQ:
  - Select the highest-priority pending & masked source (uart > alu > mouse).
  - Load VEC = {1'b1, 5'b0, id} and clear that pending bit in the same edge; this clear overrides a same-cycle set on that bit.
  - If PEND & MASK is 0 at the ack cycle, load VEC = 8'h03 (spurious) and still enter SERVICE.
- interrupt_ack outside REQ is ignored: no state change, no VEC update.
- VEC holds its value until the next ack capture.
- interrupt is driven from the state register, so it asserts 1 cycle after req rises from IDLE.
- Reset values, asserted asynchronously:
  - state IDLE; interrupt 0; irq_busy 0.
  - PEND 0; MASK 0; VEC 8'h03; irq_src_d 0.
  - Reset mid-service drops interrupt immediately and discards all pending bits.

Test Plan:
1. Reset, then MASK=3'b111, pulse irq_src[1] for 1 cycle -> PEND=3'b010; interrupt rises 2 cycles after the pulse edge. Ack -> VEC=8'h81, PEND=0, interrupt=0, irq_busy=1. EOI write -> irq_busy=0.
2. irq_src=3'b111 pulsed together, MASK=7 -> ack sequence yields VEC 8'h80, then 8'h81, then 8'h82 across three ack/EOI rounds; PEND ends at 0.
3. MASK=0, pulse mouse -> PEND=3'b100, interrupt stays 0. Write MASK=4 -> interrupt rises. Write MASK=0 before ack -> interrupt drops, state IDLE, PEND still 3'b100.
4. Enter REQ, then write PEND W1C 8'h01 in the same cycle as ack -> VEC=8'h03, SERVICE entered, irq_busy=1.
5. EDGE_MODE=3'b110, hold uart high through W1C writes -> PEND[0] stays 1. EDGE_MODE=3'b111, same-cycle uart rising edge and W1C -> PEND[0]=1 (set wins).
6. Assert reset during SERVICE with PEND=3'b110 -> interrupt=0, irq_busy=0, PEND=0, MASK=0, VEC=8'h03 without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_irq_ctrl.sv
// Prioritised three-source interrupt controller for PicoBlaze: pending/mask/vector
// registers on a 4-port I/O window, one interrupt in flight until firmware writes EOI.
module cpu_irq_ctrl #(
  parameter logic [7:0] PORT_BASE = 8'hE0,
  parameter logic [2:0] EDGE_MODE = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] irq_src,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  output logic [7:0] rd_data,
  output logic       rd_sel,
  output logic       irq_busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] mask_q, mask_d;
  logic [7:0] vec_q, vec_d;
  logic [2:0] src_d_q;

  logic       wr_en, eoi_wr, req, ack_take;
  logic [2:0] set_bits, w1c, cand, ack_clr;
  logic       unused_data;

  assign unused_data = ^out_port[7:3];

  always_comb begin
    rd_sel   = (port_id[7:2] == PORT_BASE[7:2]);
    wr_en    = write_strobe & rd_sel;
    w1c      = (wr_en && port_id[1:0] == 2'd0) ? out_port[2:0] : '0;
    eoi_wr   = wr_en && (port_id[1:0] == 2'd3);
    // Edge-mode bits need a fresh rise; level-mode bits set whenever high.
    set_bits = irq_src & (~EDGE_MODE | ~src_d_q);
    req      = |(pend_q & mask_q);
    ack_take = (state_q == S_REQ) && interrupt_ack;
    // Arbitration sees pending bits after a same-cycle W1C, so a cleared source is not vectored.
    cand     = pend_q & ~w1c & mask_q;

    ack_clr  = '0;
    vec_d    = vec_q;
    if (ack_take) begin
      if (cand[0]) begin
        ack_clr = 3'b001;
        vec_d   = 8'h80;
      end else if (cand[1]) begin
        ack_clr = 3'b010;
        vec_d   = 8'h81;
      end else if (cand[2]) begin
        ack_clr = 3'b100;
        vec_d   = 8'h82;
      end else begin
        vec_d   = 8'h03;
      end
    end

    pend_d = ((pend_q & ~w1c) | set_bits) & ~ack_clr;
    mask_d = (wr_en && port_id[1:0] == 2'd1) ? out_port[2:0] : mask_q;

    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req) state_d = S_REQ;
      S_REQ: begin
        if (interrupt_ack)  state_d = S_SERVICE;
        else if (!req)      state_d = S_IDLE;
      end
      S_SERVICE: if (eoi_wr) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      mask_q  <= '0;
      vec_q   <= 8'h03;
      src_d_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      vec_q   <= vec_d;
      src_d_q <= irq_src;
    end
  end

  assign interrupt = (state_q == S_REQ);
  assign irq_busy  = (state_q == S_SERVICE);

  always_comb begin
    rd_data = '0;
    if (rd_sel) begin
      case (port_id[1:0])
        2'd0:    rd_data = {5'b0, pend_q};
        2'd1:    rd_data = {5'b0, mask_q};
        2'd2:    rd_data = vec_q;
        default: rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Bench for cpu_irq_ctrl: vector table, directed corner sequences, and random
// traffic against a reference model kept in the bench.
module tb_cpu_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] src;
  logic [7:0] pid;
  logic       ws;
  logic [7:0] dat;
  logic       ack;

  logic       int1, sel1, busy1, int2, sel2, busy2;
  logic [7:0] rd1, rd2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  cpu_irq_ctrl #(.PORT_BASE(8'hE0), .EDGE_MODE(3'b111)) u1 (
    .clk(clk), .reset(rst), .irq_src(src), .port_id(pid), .write_strobe(ws),
    .out_port(dat), .interrupt(int1), .interrupt_ack(ack), .rd_data(rd1),
    .rd_sel(sel1), .irq_busy(busy1)
  );

  cpu_irq_ctrl #(.PORT_BASE(8'hE0), .EDGE_MODE(3'b110)) u2 (
    .clk(clk), .reset(rst), .irq_src(src), .port_id(pid), .write_strobe(ws),
    .out_port(dat), .interrupt(int2), .interrupt_ack(ack), .rd_data(rd2),
    .rd_sel(sel2), .irq_busy(busy2)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic a, input logic w, input logic [7:0] p, input logic [7:0] d);
    ack = a; ws = w; pid = p; dat = d;
    tick;
    ack = 1'b0; ws = 1'b0;
  endtask

  task automatic rd(input logic [7:0] p, output logic [7:0] v1, output logic [7:0] v2);
    pid = p;
    #1;
    v1 = rd1;
    v2 = rd2;
  endtask

  task automatic wait_int(input logic e, input int n, input string name);
    int k = 0;
    while (int1 !== e && k < n) begin
      tick;
      k++;
    end
    chk(name, {7'b0, int1}, {7'b0, e});
  endtask

  task automatic do_reset;
    src = '0; ack = 1'b0; ws = 1'b0; pid = 8'h00; dat = 8'h00;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Reference model of the default-configured instance (all sources edge-latched).
  logic [2:0] m_pend, m_mask, m_srcd;
  logic [7:0] m_vec;
  bit         m_pres, m_svc;

  function automatic logic [7:0] m_rd(input logic [7:0] p);
    if (p[7:2] != 6'h38) return 8'h00;
    case (p[1:0])
      2'd0:    return {5'b0, m_pend};
      2'd1:    return {5'b0, m_mask};
      2'd2:    return m_vec;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_reset;
    m_pend = '0; m_mask = '0; m_srcd = '0; m_vec = 8'h03; m_pres = 0; m_svc = 0;
  endtask

  task automatic m_step;
    bit         wr, any_req, acked;
    int         pick;
    logic [2:0] clr, np;
    wr      = ws && (pid[7:2] == 6'h38);
    clr     = (wr && pid[1:0] == 2'd0) ? dat[2:0] : 3'b000;
    any_req = (m_pend & m_mask) != 3'b000;
    acked   = m_pres && ack;
    pick    = -1;
    for (int i = 0; i < 3; i++)
      np[i] = (m_pend[i] && !clr[i]) || (src[i] && !m_srcd[i]);
    if (acked) begin
      for (int i = 0; i < 3; i++)
        if (pick < 0 && m_pend[i] && !clr[i] && m_mask[i]) pick = i;
      if (pick >= 0) begin
        m_vec    = 8'h80 + 8'(pick);
        np[pick] = 1'b0;
      end else begin
        m_vec = 8'h03;
      end
    end
    if (m_svc) begin
      if (wr && pid[1:0] == 2'd3) m_svc = 0;
    end else if (m_pres) begin
      if (acked) begin
        m_pres = 0;
        m_svc  = 1;
      end else if (!any_req) begin
        m_pres = 0;
      end
    end else if (any_req) begin
      m_pres = 1;
    end
    m_pend = np;
    if (wr && pid[1:0] == 2'd1) m_mask = dat[2:0];
    m_srcd = src;
  endtask

  typedef struct {
    logic [2:0] src;
    logic       ack;
    logic       ws;
    logic [7:0] pid;
    logic [7:0] dat;
    logic [7:0] exp_rd;
    logic       exp_sel;
    logic       exp_int;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [7:0] a, b;

    tbl[0]  = '{3'b000, 1'b0, 1'b1, 8'hE1, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{3'b010, 1'b0, 1'b0, 8'hE0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{3'b000, 1'b0, 1'b0, 8'hE0, 8'h00, 8'h02, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{3'b000, 1'b0, 1'b0, 8'hE2, 8'h00, 8'h03, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{3'b000, 1'b1, 1'b0, 8'hE2, 8'h00, 8'h03, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{3'b000, 1'b0, 1'b0, 8'hE2, 8'h00, 8'h81, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{3'b000, 1'b0, 1'b0, 8'hE0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{3'b000, 1'b0, 1'b0, 8'hE3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{3'b000, 1'b0, 1'b1, 8'hE3, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{3'b000, 1'b0, 1'b0, 8'hE1, 8'h00, 8'h07, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{3'b000, 1'b0, 1'b1, 8'hE5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{3'b000, 1'b0, 1'b0, 8'hE1, 8'h00, 8'h07, 1'b1, 1'b0, 1'b0};

    // Reset values
    src = '0; ack = 1'b0; ws = 1'b0; pid = 8'h00; dat = 8'h00;
    rst = 1'b1;
    #2;
    chk("reset_int", {7'b0, int1}, 8'h00);
    chk("reset_busy", {7'b0, busy1}, 8'h00);
    rd(8'hE0, a, b); chk("reset_pend", a, 8'h00);
    rd(8'hE1, a, b); chk("reset_mask", a, 8'h00);
    rd(8'hE2, a, b); chk("reset_vec", a, 8'h03);
    do_reset;

    // Single-source pulse, ack, EOI, decode checks
    for (int i = 0; i < 12; i++) begin
      src = tbl[i].src; ack = tbl[i].ack; ws = tbl[i].ws;
      pid = tbl[i].pid; dat = tbl[i].dat;
      #1;
      chk($sformatf("tbl%0d_rd", i), rd1, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_sel", i), {7'b0, sel1}, {7'b0, tbl[i].exp_sel});
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_int", i), {7'b0, int1}, {7'b0, tbl[i].exp_int});
      chk($sformatf("tbl%0d_busy", i), {7'b0, busy1}, {7'b0, tbl[i].exp_busy});
    end
    ack = 1'b0; ws = 1'b0; src = '0;

    // All three sources at once: serviced in priority order
    do_reset;
    cyc(0, 1, 8'hE1, 8'h07);
    src = 3'b111;
    cyc(0, 0, 8'h00, 8'h00);
    src = 3'b000;
    for (int r = 0; r < 3; r++) begin
      wait_int(1, 5, $sformatf("prio%0d_int", r));
      cyc(1, 0, 8'hE2, 8'h00);
      rd(8'hE2, a, b); chk($sformatf("prio%0d_vec", r), a, 8'h80 + 8'(r));
      chk($sformatf("prio%0d_busy", r), {7'b0, busy1}, 8'h01);
      cyc(0, 1, 8'hE3, 8'h00);
    end
    tick;
    rd(8'hE0, a, b); chk("prio_pend_end", a, 8'h00);
    chk("prio_int_end", {7'b0, int1}, 8'h00);

    // Mask gating and withdrawal from REQ
    do_reset;
    src = 3'b100;
    cyc(0, 0, 8'h00, 8'h00);
    src = 3'b000;
    tick; tick;
    rd(8'hE0, a, b); chk("mask_pend", a, 8'h04);
    chk("mask_int_off", {7'b0, int1}, 8'h00);
    cyc(0, 1, 8'hE1, 8'h04);
    wait_int(1, 4, "mask_int_on");
    cyc(0, 1, 8'hE1, 8'h00);
    wait_int(0, 3, "mask_int_drop");
    chk("mask_busy", {7'b0, busy1}, 8'h00);
    tick;
    chk("mask_stay_idle", {7'b0, int1}, 8'h00);
    rd(8'hE0, a, b); chk("mask_pend_kept", a, 8'h04);

    // W1C in the ack cycle leaves nothing to vector: spurious
    do_reset;
    cyc(0, 1, 8'hE1, 8'h01);
    src = 3'b001;
    cyc(0, 0, 8'h00, 8'h00);
    src = 3'b000;
    wait_int(1, 4, "spur_int");
    cyc(1, 1, 8'hE0, 8'h01);
    chk("spur_busy", {7'b0, busy1}, 8'h01);
    chk("spur_int_off", {7'b0, int1}, 8'h00);
    rd(8'hE2, a, b); chk("spur_vec", a, 8'h03);
    rd(8'hE0, a, b); chk("spur_pend", a, 8'h00);
    cyc(0, 1, 8'hE3, 8'h00);
    chk("spur_eoi", {7'b0, busy1}, 8'h00);

    // Level vs edge with W1C while the source is held high
    do_reset;
    src = 3'b001;
    cyc(0, 0, 8'h00, 8'h00);
    for (int r = 0; r < 3; r++) begin
      cyc(0, 1, 8'hE0, 8'h01);
      rd(8'hE0, a, b);
      chk($sformatf("level%0d_pend", r), b & 8'h01, 8'h01);
      chk($sformatf("edge%0d_pend", r), a & 8'h01, 8'h00);
    end
    src = 3'b000;
    cyc(0, 1, 8'hE0, 8'h01);
    rd(8'hE0, a, b); chk("level_cleared", b & 8'h01, 8'h00);
    src = 3'b001;
    cyc(0, 1, 8'hE0, 8'h01);
    src = 3'b000;
    rd(8'hE0, a, b); chk("edge_set_wins", a & 8'h01, 8'h01);

    // Asynchronous reset in the middle of service
    do_reset;
    cyc(0, 1, 8'hE1, 8'h07);
    src = 3'b111;
    cyc(0, 0, 8'h00, 8'h00);
    src = 3'b000;
    wait_int(1, 4, "rst_pre_int");
    cyc(1, 0, 8'h00, 8'h00);
    chk("rst_pre_busy", {7'b0, busy1}, 8'h01);
    rd(8'hE0, a, b); chk("rst_pre_pend", a, 8'h06);
    rst = 1'b1;
    #1;
    chk("rst_async_int", {7'b0, int1}, 8'h00);
    chk("rst_async_busy", {7'b0, busy1}, 8'h00);
    rd(8'hE0, a, b); chk("rst_async_pend", a, 8'h00);
    rd(8'hE1, a, b); chk("rst_async_mask", a, 8'h00);
    rd(8'hE2, a, b); chk("rst_async_vec", a, 8'h03);
    tick;
    rst = 1'b0;

    // Random traffic against the model
    do_reset;
    m_reset;
    for (int c = 0; c < 3000; c++) begin
      src = 3'($urandom);
      ack = m_pres ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      ws  = ($urandom_range(0, 3) == 0);
      pid = {($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h38, 2'($urandom)};
      dat = 8'($urandom);
      #1;
      if (rd1 !== m_rd(pid) || sel1 !== (pid[7:2] == 6'h38)) begin
        chk($sformatf("rnd%0d_rd", c), rd1, m_rd(pid));
        chk($sformatf("rnd%0d_sel", c), {7'b0, sel1}, {7'b0, pid[7:2] == 6'h38});
      end else begin
        n_checks += 2;
      end
      @(posedge clk);
      m_step;
      #1;
      chk($sformatf("rnd%0d_int", c), {7'b0, int1}, {7'b0, m_pres});
      chk($sformatf("rnd%0d_busy", c), {7'b0, busy1}, {7'b0, m_svc});
    end
    ack = 1'b0; ws = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
